// File: rtl/maze_mc_replicator.sv
// MAZE injection-side replicator: pass-through register stage, or serial
// expansion of multicast/broadcast into unicast copies around one faulty node.
module maze_mc_replicator #(
  parameter int MESH_W    = 8,
  parameter int MESH_H    = 8,
  parameter int COORD_W   = 3,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_pkt_type,
  input  logic [COORD_W-1:0]   in_src_x,
  input  logic [COORD_W-1:0]   in_src_y,
  input  logic [COORD_W-1:0]   in_tgt_x,
  input  logic [COORD_W-1:0]   in_tgt_y,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 pg_en,
  input  logic [COORD_W-1:0]   pg_node_x,
  input  logic [COORD_W-1:0]   pg_node_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_pkt_type,
  output logic [COORD_W-1:0]   out_src_x,
  output logic [COORD_W-1:0]   out_src_y,
  output logic [COORD_W-1:0]   out_tgt_x,
  output logic [COORD_W-1:0]   out_tgt_y,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_last,
  output logic                 busy,
  output logic [2*COORD_W:0]   copy_cnt
);

  localparam int CW1   = COORD_W + 1;
  localparam int CNT_W = 2 * COORD_W + 1;
  localparam logic [CW1-1:0] ONE    = CW1'(1);
  localparam logic [CW1-1:0] W_LAST = CW1'(MESH_W - 1);
  localparam logic [CW1-1:0] W_END  = CW1'(MESH_W);
  localparam logic [CW1-1:0] H_END  = CW1'(MESH_H);

  typedef enum logic [1:0] {IDLE, HOLD, EXPAND} state_t;

  state_t state, state_n;

  logic [1:0]         cap_type;
  logic [COORD_W-1:0] flt_x, flt_y;

  logic direct, accept, ld_pass, ld_exp, step, drop;

  logic [CW1-1:0] fst_x, fst_y, fst_nx, fst_ny;
  logic [CW1-1:0] cur_x, cur_y, adv_x, adv_y, adv_nx, adv_ny;
  logic           fst_last, adv_last;

  function automatic logic [2*CW1-1:0] step_raw(
    input logic [1:0]     t,
    input logic [CW1-1:0] x,
    input logic [CW1-1:0] y
  );
    logic [CW1-1:0] nx, ny;
    nx = x;
    ny = y;
    case (t)
      2'b01: ny = y + ONE;
      2'b10: nx = x + ONE;
      default: begin
        if (x == W_LAST) begin
          nx = '0;
          ny = y + ONE;
        end else begin
          nx = x + ONE;
        end
      end
    endcase
    return {nx, ny};
  endfunction

  function automatic logic is_fault(
    input logic [CW1-1:0]     x,
    input logic [CW1-1:0]     y,
    input logic [COORD_W-1:0] fx,
    input logic [COORD_W-1:0] fy
  );
    return (x == {1'b0, fx}) && (y == {1'b0, fy});
  endfunction

  // A single fault can only cost one extra step.
  function automatic logic [2*CW1-1:0] next_dest(
    input logic [1:0]         t,
    input logic [CW1-1:0]     x,
    input logic [CW1-1:0]     y,
    input logic [COORD_W-1:0] fx,
    input logic [COORD_W-1:0] fy
  );
    logic [CW1-1:0] ax, ay;
    {ax, ay} = step_raw(t, x, y);
    if (is_fault(ax, ay, fx, fy))
      {ax, ay} = step_raw(t, ax, ay);
    return {ax, ay};
  endfunction

  function automatic logic in_mesh(
    input logic [1:0]     t,
    input logic [CW1-1:0] x,
    input logic [CW1-1:0] y
  );
    return (t == 2'b10) ? (x < W_END) : (y < H_END);
  endfunction

  assign direct = ~pg_en | (in_pkt_type == 2'b00);

  always_comb begin
    fst_x = '0;
    fst_y = '0;
    case (in_pkt_type)
      2'b01:   fst_x = {1'b0, in_tgt_x};
      2'b10:   fst_y = {1'b0, in_tgt_y};
      default: ;
    endcase
    if (is_fault(fst_x, fst_y, pg_node_x, pg_node_y))
      {fst_x, fst_y} = step_raw(in_pkt_type, fst_x, fst_y);
    {fst_nx, fst_ny} = next_dest(in_pkt_type, fst_x, fst_y,
                                 pg_node_x, pg_node_y);
    fst_last = ~in_mesh(in_pkt_type, fst_nx, fst_ny);
    cur_x = {1'b0, out_tgt_x};
    cur_y = {1'b0, out_tgt_y};
    {adv_x, adv_y} = next_dest(cap_type, cur_x, cur_y, flt_x, flt_y);
    {adv_nx, adv_ny} = next_dest(cap_type, adv_x, adv_y, flt_x, flt_y);
    adv_last = ~in_mesh(cap_type, adv_nx, adv_ny);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_n = direct ? HOLD : EXPAND;
      end
      HOLD: begin
        if (out_ready)
          state_n = in_valid ? (direct ? HOLD : EXPAND) : IDLE;
      end
      EXPAND: begin
        if (out_ready && out_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept  = in_valid & in_ready;
    ld_pass = accept & direct;
    ld_exp  = accept & ~direct;
    step    = (state == EXPAND) & out_ready & ~out_last;
    drop    = ~accept & out_ready &
              ((state == HOLD) | ((state == EXPAND) & out_last));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      copy_cnt     <= '0;
      out_pkt_type <= '0;
      out_src_x    <= '0;
      out_src_y    <= '0;
      out_tgt_x    <= '0;
      out_tgt_y    <= '0;
      out_payload  <= '0;
      cap_type     <= '0;
      flt_x        <= '0;
      flt_y        <= '0;
    end else if (ld_pass) begin
      out_valid    <= 1'b1;
      out_last     <= 1'b1;
      busy         <= 1'b0;
      copy_cnt     <= CNT_W'(1);
      out_pkt_type <= in_pkt_type;
      out_src_x    <= in_src_x;
      out_src_y    <= in_src_y;
      out_tgt_x    <= in_tgt_x;
      out_tgt_y    <= in_tgt_y;
      out_payload  <= in_payload;
    end else if (ld_exp) begin
      out_valid    <= 1'b1;
      out_last     <= fst_last;
      busy         <= 1'b1;
      copy_cnt     <= CNT_W'(1);
      out_pkt_type <= 2'b00;
      out_src_x    <= in_src_x;
      out_src_y    <= in_src_y;
      out_tgt_x    <= fst_x[COORD_W-1:0];
      out_tgt_y    <= fst_y[COORD_W-1:0];
      out_payload  <= in_payload;
      cap_type     <= in_pkt_type;
      flt_x        <= pg_node_x;
      flt_y        <= pg_node_y;
    end else if (step) begin
      out_last     <= adv_last;
      copy_cnt     <= copy_cnt + CNT_W'(1);
      out_tgt_x    <= adv_x[COORD_W-1:0];
      out_tgt_y    <= adv_y[COORD_W-1:0];
    end else if (drop) begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      copy_cnt     <= '0;
    end
  end

endmodule
